// File: rtl/rv_muldiv_iter_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface rv_muldiv_iter_if #(
  parameter int XLEN = 32
);
  logic            rdy;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output rdy, start, op, rs1, rs2, kill, input busy, done, result);
  modport slave  (input rdy, start, op, rs1, rs2, kill, output busy, done, result);
endinterface

// File: rtl/rv_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply, restoring divide,
// STEP bits per cycle, early-out on divide-by-zero and signed overflow.
module rv_muldiv_iter #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input logic             clk,
  input logic             reset,
  rv_muldiv_iter_if.slave bus
);
  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  if (!((XLEN == 32 || XLEN == 64) && (STEP == 1 || STEP == 2 || STEP == 4) && (XLEN % STEP == 0)))
  begin : g_param_check
    $error("rv_muldiv_iter: unsupported XLEN/STEP combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              sign1_q, sign2_q;
  logic [XLEN-1:0]   opb_q;
  logic [2*XLEN-1:0] acc_q, acc_next;
  logic [CW-1:0]     count;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  logic            signed_op1, signed_op2, sign1, sign2;
  logic            div_zero, div_ovf, early;
  logic [XLEN-1:0] mag1, mag2, early_res;

  // MIN_INT negates to itself; as an unsigned magnitude that is exactly right.
  always_comb begin
    signed_op1 = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    signed_op2 = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    sign1      = signed_op1 && bus.rs1[XLEN-1];
    sign2      = signed_op2 && bus.rs2[XLEN-1];
    mag1       = sign1 ? -bus.rs1 : bus.rs1;
    mag2       = sign2 ? -bus.rs2 : bus.rs2;
    div_zero   = bus.op[2] && (bus.rs2 == '0);
    div_ovf    = bus.op[2] && !bus.op[0] && (bus.rs1 == MIN_INT) && (bus.rs2 == '1);
    early      = div_zero || div_ovf;
    if (div_zero) early_res = bus.op[1] ? bus.rs1 : '1;
    else          early_res = bus.op[1] ? '0 : MIN_INT;
  end

  logic [XLEN:0] sum, diff;

  // acc holds {hi, lo}: multiply shifts product in from the top while consuming the
  // multiplier from lo; divide shifts the dividend out of lo into the remainder in hi.
  always_comb begin
    acc_next = acc_q;
    sum      = '0;
    diff     = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (op_q[2]) begin
        diff = acc_next[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc_next[XLEN-2:0], 1'b1};
        else             acc_next = {acc_next[2*XLEN-2:0], 1'b0};
      end else begin
        sum      = {1'b0, acc_next[2*XLEN-1:XLEN]} + (acc_next[0] ? {1'b0, opb_q} : '0);
        acc_next = {sum, acc_next[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_res;

  always_comb begin
    prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
    quot = (sign1_q ^ sign2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sign1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:             fix_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_res = quot;
      default:          fix_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      count    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.kill) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.rdy) begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            sign1_q <= sign1;
            sign2_q <= sign2;
            if (early) begin
              result_q <= early_res;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end else begin
              opb_q  <= bus.op[2] ? mag2 : mag1;
              acc_q  <= {{XLEN{1'b0}}, (bus.op[2] ? mag1 : mag2)};
              count  <= CW'(N);
              busy_q <= 1'b1;
              state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_q <= acc_next;
          count <= count - 1'b1;
          if (count == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv_muldiv_iter.sv
// Bench: four configurations driven in lockstep against a cycle-counting arithmetic model.
module tb_rv_muldiv_iter;
  localparam int NDUT = 4;
  localparam int XL  [NDUT] = '{32, 32, 32, 64};
  localparam int LAT [NDUT] = '{18, 34, 10, 18};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, rdy = 1'b1, start = 1'b0, kill = 1'b0;
  logic [2:0]  op  = '0;
  logic [63:0] rs1 = '0, rs2 = '0;

  rv_muldiv_iter_if #(.XLEN(32)) if_s2 ();
  rv_muldiv_iter_if #(.XLEN(32)) if_s1 ();
  rv_muldiv_iter_if #(.XLEN(32)) if_s4 ();
  rv_muldiv_iter_if #(.XLEN(64)) if_w64 ();

  assign if_s2.rdy = rdy;   assign if_s2.start = start;   assign if_s2.op = op;   assign if_s2.kill = kill;
  assign if_s2.rs1 = rs1[31:0];   assign if_s2.rs2 = rs2[31:0];
  assign if_s1.rdy = rdy;   assign if_s1.start = start;   assign if_s1.op = op;   assign if_s1.kill = kill;
  assign if_s1.rs1 = rs1[31:0];   assign if_s1.rs2 = rs2[31:0];
  assign if_s4.rdy = rdy;   assign if_s4.start = start;   assign if_s4.op = op;   assign if_s4.kill = kill;
  assign if_s4.rs1 = rs1[31:0];   assign if_s4.rs2 = rs2[31:0];
  assign if_w64.rdy = rdy;  assign if_w64.start = start;  assign if_w64.op = op;  assign if_w64.kill = kill;
  assign if_w64.rs1 = rs1;  assign if_w64.rs2 = rs2;

  rv_muldiv_iter #(.XLEN(32), .STEP(2)) u_s2  (.clk(clk), .reset(reset), .bus(if_s2));
  rv_muldiv_iter #(.XLEN(32), .STEP(1)) u_s1  (.clk(clk), .reset(reset), .bus(if_s1));
  rv_muldiv_iter #(.XLEN(32), .STEP(4)) u_s4  (.clk(clk), .reset(reset), .bus(if_s4));
  rv_muldiv_iter #(.XLEN(64), .STEP(4)) u_w64 (.clk(clk), .reset(reset), .bus(if_w64));

  logic [63:0] res_v  [NDUT];
  logic        busy_v [NDUT];
  logic        done_v [NDUT];
  assign res_v[0] = {32'b0, if_s2.result};  assign busy_v[0] = if_s2.busy;  assign done_v[0] = if_s2.done;
  assign res_v[1] = {32'b0, if_s1.result};  assign busy_v[1] = if_s1.busy;  assign done_v[1] = if_s1.done;
  assign res_v[2] = {32'b0, if_s4.result};  assign busy_v[2] = if_s4.busy;  assign done_v[2] = if_s4.done;
  assign res_v[3] = if_w64.result;          assign busy_v[3] = if_w64.busy; assign done_v[3] = if_w64.done;

  // Model: phase 0 idle, 1 computing, 2 result presented; rem_c counts enabled cycles left.
  int          ph    [NDUT];
  int          rem_c [NDUT];
  logic [63:0] m_res [NDUT];
  logic [63:0] m_pend[NDUT];
  int          lat_seen [NDUT];
  bit          seen [NDUT];
  int          cyc = 0, t0 = 0;
  int          checks = 0, errors = 0;

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] xmask(input int xl);
    return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] xmin(input int xl);
    return (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
  endfunction

  function automatic bit is_early(input int xl, input logic [2:0] f, input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] a, b;
    a = a_in & xmask(xl);
    b = b_in & xmask(xl);
    return f[2] && ((b == 64'd0) || (!f[0] && a == xmin(xl) && b == xmask(xl)));
  endfunction

  function automatic logic [63:0] ref_calc(input int xl, input logic [2:0] f, input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0]  mask, a, b, q, r, res;
    logic [127:0] ua, ub, sa, sb, p;
    longint       sa64, sb64;
    mask = xmask(xl);
    a  = a_in & mask;
    b  = b_in & mask;
    ua = {64'b0, a};
    ub = {64'b0, b};
    sa = a[xl-1] ? (ua | ~{64'b0, mask}) : ua;
    sb = b[xl-1] ? (ub | ~{64'b0, mask}) : ub;
    q = '0;
    r = '0;
    case (f)
      3'd0: begin p = ua * ub; res = p[63:0]; end
      3'd1: begin p = (sa * sb) >> xl; res = p[63:0]; end
      3'd2: begin p = (sa * ub) >> xl; res = p[63:0]; end
      3'd3: begin p = (ua * ub) >> xl; res = p[63:0]; end
      3'd4, 3'd6: begin
        if (b == 64'd0) begin q = mask; r = a; end
        else if (a == xmin(xl) && b == mask) begin q = xmin(xl); r = '0; end
        else begin
          sa64 = sa[63:0];
          sb64 = sb[63:0];
          q = sa64 / sb64;
          r = sa64 % sb64;
        end
        res = (f == 3'd4) ? q : r;
      end
      default: begin
        if (b == 64'd0) begin q = mask; r = a; end
        else begin q = a / b; r = a % b; end
        res = (f == 3'd5) ? q : r;
      end
    endcase
    return res & mask;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      if (reset) begin
        ph[i] = 0;
        m_res[i] = '0;
      end else if (kill) begin
        ph[i] = 0;
      end else if (rdy) begin
        case (ph[i])
          0: if (start) begin
            m_pend[i] = ref_calc(XL[i], op, rs1, rs2);
            if (is_early(XL[i], op, rs1, rs2)) begin
              ph[i] = 2;
              m_res[i] = m_pend[i];
            end else begin
              ph[i] = 1;
              rem_c[i] = LAT[i] - 1;
            end
          end
          1: begin
            rem_c[i]--;
            if (rem_c[i] == 0) begin
              ph[i] = 2;
              m_res[i] = m_pend[i];
            end
          end
          default: ph[i] = 0;
        endcase
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("d%0d_busy", i), 64'(busy_v[i]), 64'(ph[i] == 1));
      chk($sformatf("d%0d_done", i), 64'(done_v[i]), 64'(ph[i] == 2));
      if (ph[i] != 1) chk($sformatf("d%0d_result", i), res_v[i], m_res[i]);
      if (done_v[i] && !seen[i]) begin
        seen[i] = 1'b1;
        lat_seen[i] = cyc - t0;
      end
    end
  endtask

  // Inputs change at the falling edge; the model samples them with the DUT at the rising edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  function automatic bit any_active();
    bit a = 1'b0;
    for (int i = 0; i < NDUT; i++) a |= busy_v[i] | done_v[i];
    return a;
  endfunction

  task automatic mark_start();
    t0 = cyc;
    for (int i = 0; i < NDUT; i++) begin
      seen[i] = 1'b0;
      lat_seen[i] = -1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (any_active() && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(any_active()), 64'd0);
  endtask

  task automatic run_dir(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    op = f;
    rs1 = a;
    rs2 = b;
    mark_start();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(200);
  endtask

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        early;
  } vec_t;

  vec_t tab [12];

  initial begin
    tab = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
      '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0},
      '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0},
      '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0},
      '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0},
      '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0},
      '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1},
      '{3'd7, 32'd5,         32'd0,         32'd5,         1'b1},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1}
    };
    for (int i = 0; i < NDUT; i++) begin
      ph[i] = 0;
      rem_c[i] = 0;
      m_res[i] = '0;
      m_pend[i] = '0;
      seen[i] = 1'b0;
      lat_seen[i] = -1;
    end

    // Reset must dominate a simultaneous start and kill.
    step();
    start = 1'b1;
    kill  = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    step();
    chk("rst_result", res_v[0], 64'd0);
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_done", 64'(done_v[0]), 64'd0);

    for (int k = 0; k < 12; k++) begin
      run_dir(tab[k].f, sx(tab[k].a), sx(tab[k].b));
      chk($sformatf("vec%0d_result", k), res_v[0], {32'b0, tab[k].exp});
      chk($sformatf("vec%0d_model", k), ref_calc(32, tab[k].f, {32'b0, tab[k].a}, {32'b0, tab[k].b}), {32'b0, tab[k].exp});
      chk($sformatf("vec%0d_lat", k), 64'(lat_seen[0]), tab[k].early ? 64'd1 : 64'd18);
      for (int i = 1; i < NDUT; i++)
        chk($sformatf("vec%0d_lat_d%0d", k, i), 64'(lat_seen[i]),
            is_early(XL[i], tab[k].f, sx(tab[k].a), sx(tab[k].b)) ? 64'd1 : 64'(LAT[i]));
    end

    // MUL 7*3 with rdy low on cycles 4..8 and a stray MULH start on cycle 6.
    op = 3'd0;
    rs1 = 64'd7;
    rs2 = 64'd3;
    mark_start();
    start = 1'b1;
    step();
    for (int c = 1; c < 120; c++) begin
      rdy   = !(c >= 4 && c <= 8);
      start = (c == 6);
      op    = (c == 6) ? 3'd1 : 3'd0;
      step();
      if (!any_active()) break;
    end
    start = 1'b0;
    rdy   = 1'b1;
    op    = 3'd0;
    chk("stall_result", res_v[0], 64'd21);
    chk("stall_lat_s2", 64'(lat_seen[0]), 64'd23);
    chk("stall_lat_s1", 64'(lat_seen[1]), 64'd39);
    chk("stall_lat_s4", 64'(lat_seen[2]), 64'd15);
    chk("stall_lat_w64", 64'(lat_seen[3]), 64'd23);
    wait_idle(20);

    // Kill on cycle 5 of a DIV.
    op = 3'd4;
    rs1 = sx(32'hFFFF_FFF9);
    rs2 = 64'd2;
    mark_start();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_busy", 64'(busy_v[0]), 64'd0);
    chk("kill_done", 64'(done_v[0]), 64'd0);
    for (int c = 0; c < 40; c++) step();
    chk("kill_done_seen", 64'(seen[0]), 64'd0);
    chk("kill_result", res_v[0], 64'd21);

    // Reset on cycle 3 of a MUL.
    op = 3'd0;
    rs1 = 64'd9;
    rs2 = 64'd5;
    mark_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst3_busy", 64'(busy_v[0]), 64'd0);
    chk("rst3_done", 64'(done_v[0]), 64'd0);
    chk("rst3_result", res_v[0], 64'd0);
    chk("rst3_result_w64", res_v[3], 64'd0);
    wait_idle(10);

    // Randomized operations with random rdy stalls and occasional kills.
    for (int k = 0; k < 1000; k++) begin
      int n;
      int sel;
      sel = $urandom_range(0, 7);
      op  = 3'($urandom_range(0, 7));
      rs1 = {$urandom, $urandom};
      rs2 = {$urandom, $urandom};
      case (sel)
        0: rs2 = '0;
        1: begin rs1 = sx(32'h8000_0000); rs2 = '1; end
        2: begin rs1 = 64'h8000_0000_0000_0000; rs2 = '1; end
        3: begin rs1 = 64'($urandom_range(0, 300)); rs2 = 64'($urandom_range(0, 20)); end
        4: rs2 = sx(32'($urandom_range(0, 15)) | 32'hFFFF_FFF0);
        default: ;
      endcase
      mark_start();
      start = 1'b1;
      n = 0;
      do begin
        rdy  = ($urandom_range(0, 7) != 0);
        kill = ($urandom_range(0, 63) == 0);
        step();
        n++;
      end while (!(busy_v[0] || done_v[0]) && n < 50);
      start = 1'b0;
      if (n >= 50) chk("accept_timeout", 64'(busy_v[0] || done_v[0]), 64'd1);
      n = 0;
      while (any_active() && n < 600) begin
        rdy  = ($urandom_range(0, 7) != 0);
        kill = ($urandom_range(0, 63) == 0);
        step();
        n++;
      end
      rdy  = 1'b1;
      kill = 1'b0;
      chk("rand_idle_timeout", 64'(any_active()), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
